// File: rtl/fu_alu_arb_pkg.sv
// fu_alu_arb_pkg: shared types for the shared-ALU issue arbiter.
// Perf counters in fu_alu_arbiter are enabled by FU_ALU_ARB_PERF_EN.
package fu_alu_arb_pkg;

  typedef logic [31:0] word_t;

  // Sized for the widest configuration; narrower tags/indices zero-extend.
  localparam int TAG_W = 8;
  localparam int SRC_W = 3;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    aluop_t           aluop;
    word_t            port_a;
    word_t            port_b;
    logic [TAG_W-1:0] rd;
  } alu_req_t;

  typedef struct packed {
    word_t            result;
    logic [2:0]       flags;
    logic [TAG_W-1:0] rd;
    logic [SRC_W-1:0] src;
  } alu_res_t;

  function automatic logic [2:0] pack_flags(
    input logic n,
    input logic v,
    input logic z
  );
    logic [2:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/fu_alu_if.sv
// fu_alu_if: connection to a combinational integer ALU.
// tb/master drive operands; alu/slave return result and flags.
interface fu_alu_if;
  import fu_alu_arb_pkg::*;

  logic [3:0] aluop;
  word_t      port_a;
  word_t      port_b;
  word_t      port_output;
  logic       negative;
  logic       overflow;
  logic       zero;

  modport alu (
    input  aluop, port_a, port_b,
    output port_output, negative, overflow, zero
  );

  modport tb (
    output aluop, port_a, port_b,
    input  port_output, negative, overflow, zero
  );

  modport slave (
    input  aluop, port_a, port_b,
    output port_output, negative, overflow, zero
  );

  modport master (
    output aluop, port_a, port_b,
    input  port_output, negative, overflow, zero
  );

endinterface

// File: rtl/fu_alu_arbiter_rr.sv
// rr_arbiter: rotating-priority grant, scan starts at ptr and wraps.
// gnt is one-hot and gated by en; gnt_idx is valid whenever any req is set.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fu_alu_arbiter.sv
// fu_alu_arbiter: round-robin issue of NREQ requesters onto one ALU.
// Two registered stages (issue, result); FU_ALU_ARB_PERF_EN adds counters.
module fu_alu_arbiter
  import fu_alu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int TAGW = 5,
  localparam int SW   = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*4-1:0]    req_aluop,
  input  logic [NREQ*32-1:0]   req_port_a,
  input  logic [NREQ*32-1:0]   req_port_b,
  input  logic [NREQ*TAGW-1:0] req_rd,
  fu_alu_if.tb                 alu,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output word_t                wb_result,
  output logic [TAGW-1:0]      wb_rd,
  output logic [SW-1:0]        wb_src,
  output logic [2:0]           wb_flags
`ifdef FU_ALU_ARB_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_idle
`endif
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_adv;
  logic             accept;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    nxt_ptr;
  logic [SW-1:0]    gidx;
  logic [NREQ-1:0]  gnt;
  alu_req_t         s1_req;
  alu_req_t         nxt_req;
  logic [SRC_W-1:0] s1_src;
  alu_res_t         s2_res;

  assign s2_adv  = s1_valid && (!s2_valid || wb_ready);
  assign s1_load = !s1_valid || s2_adv;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (s1_load),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  // gnt is already qualified by req_valid and s1_load
  assign req_ready = gnt;
  assign accept    = |gnt;

  assign nxt_ptr = (gidx == SW'(NREQ - 1)) ? '0 : gidx + SW'(1);

  always_comb begin
    nxt_req        = '0;
    nxt_req.aluop  = aluop_t'(req_aluop[4*int'(gidx) +: 4]);
    nxt_req.port_a = req_port_a[32*int'(gidx) +: 32];
    nxt_req.port_b = req_port_b[32*int'(gidx) +: 32];
    nxt_req.rd     = TAG_W'(req_rd[TAGW*int'(gidx) +: TAGW]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_src   <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_req   <= nxt_req;
      s1_src   <= SRC_W'(gidx);
      rr_ptr   <= nxt_ptr;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign alu.aluop  = s1_req.aluop;
  assign alu.port_a = s1_req.port_a;
  assign alu.port_b = s1_req.port_b;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_adv) begin
      s2_valid      <= 1'b1;
      s2_res.result <= alu.port_output;
      s2_res.flags  <= pack_flags(alu.negative,
                                  alu.overflow,
                                  alu.zero);
      s2_res.rd     <= s1_req.rd;
      s2_res.src    <= s1_src;
    end else if (wb_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign wb_valid  = s2_valid;
  assign wb_result = s2_res.result;
  assign wb_rd     = TAGW'(s2_res.rd);
  assign wb_src    = SW'(s2_res.src);
  assign wb_flags  = s2_res.flags;

`ifdef FU_ALU_ARB_PERF_EN
  logic any_req;
  assign any_req = |req_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_idle   <= '0;
    end else begin
      if (accept && perf_issued != '1)
        perf_issued <= perf_issued + 32'd1;
      if (any_req && !accept && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
      if (!s1_valid && !s2_valid && !any_req
          && perf_idle != '1)
        perf_idle <= perf_idle + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fu_alu_arbiter.md
Name: fu_alu_arbiter

Overview:
- Shares one combinational integer ALU (fu_alu_if, alu modport) between NREQ issue requesters, e.g. per-warp reservation stations.
- Round-robin arbitration and a two-stage registered pipeline (issue register, then result register).
- Valid/ready handshakes on both the requester side and the writeback side.
- Sits between the dispatch stage and the writeback/CDB arbiter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 5, destination register tag width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester op valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_aluop  in  NREQ*4  packed aluop; slice i belongs to requester i.
- req_port_a  in  NREQ*32  packed operand A (word_t).
- req_port_b  in  NREQ*32  packed operand B.
- req_rd  in  NREQ*TAGW  packed destination tag.
- alu.aluop / alu.port_a / alu.port_b  out  4/32/32  driven from the issue register.
- alu.port_output / alu.negative / alu.overflow / alu.zero  in  32/1/1/1  ALU result.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accept.
- wb_result  out  32  registered ALU output.
- wb_rd  out  TAGW  destination tag.
- wb_src  out  clog2(NREQ)  originating requester index.
- wb_flags  out  3  {negative, overflow, zero}.
- The ALU connection is a fu_alu_if instance; this block uses the tb-direction signals. Clock is CLK, reset is nRST (asynchronous, active-low).

Behaviour:
- Reset (nRST low, asynchronous): s1_valid=0, s2_valid=0, rr_ptr=0, wb_valid=0, wb_result=0, wb_rd=0, wb_src=0, wb_flags=0. ALU drive registers are cleared to 0 (aluop=ALU_ADD encoding 0). All in-flight ops are discarded.
- Stage advance:
  - s2_adv = s1_valid && (!s2_valid || wb_ready).
  - s1_load = !s1_valid || s2_adv.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit is the grant.
  - req_ready[g] = s1_load. All other req_ready bits are 0, and all bits are 0 when no request is valid.
  - A request is accepted when req_valid[g] && req_ready[g].
- Pointer: on acceptance, rr_ptr <= (g+1) mod NREQ. Otherwise it holds. Wrap goes NREQ-1 -> 0.
- Issue register (S1): on acceptance, latch aluop, port_a, port_b, rd, and src=g; set s1_valid=1. If s2_adv and no acceptance, clear s1_valid. S1 drives the ALU continuously.
- Result register (S2): on s2_adv, capture port_output, flags, and the S1 tag and src; set s2_valid=1. If wb_ready && s2_valid && !s2_adv, clear s2_valid.
- wb_valid = s2_valid. Outputs are stable while wb_valid && !wb_ready.
- Latency: acceptance at edge N gives wb_valid high after edge N+1 (2 cycles). Throughput is 1 op/cycle with wb_ready held high.
- Full pipeline with wb_ready=0: S2 holds, S1 holds, all req_ready=0. No op is lost or duplicated.
- Simultaneous events: a wb handshake and an S2 reload in the same cycle are legal (bubble-free). A requester that deasserts req_valid without acceptance has no effect.
- Operands are passed unmodified; width is 32-bit. Flags come from the ALU, not recomputed.

Optional Feature:
- FU_ALU_ARB_PERF_EN defined:
  - Adds outputs perf_issued (32), perf_stall (32), perf_idle (32).
  - perf_issued counts acceptances.
  - perf_stall counts cycles with any req_valid high but no acceptance.
  - perf_idle counts cycles with s1_valid=0 && s2_valid=0 && no req_valid.
  - Counters saturate at 2^32-1 and reset to 0.
- FU_ALU_ARB_PERF_EN undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Package fu_alu_arb_pkg holds:
  - typedef alu_req_t {aluop[3:0], port_a word_t, port_b word_t, rd[TAGW-1:0]}.
  - typedef alu_res_t {result, flags[2:0], rd, src}.
  - localparam FLAG_N=2, FLAG_V=1, FLAG_Z=0.
- Sub-module rr_arbiter (params N; in req[N], ptr, en; out gnt one-hot, gnt_idx) holds the rotate/priority-encode logic and is reused by the writeback arbiter.

Test Plan:
- Single op: req0 ADD A=5 B=7 rd=3, wb_ready=1 -> wb_valid 2 cycles later; wb_result=12, wb_rd=3, wb_src=0, flags=000.
- Round-robin fairness: all 4 requesters valid continuously, wb_ready=1 -> grant order 0,1,2,3,0; one acceptance per cycle; rr_ptr wraps 3->0.
- Backpressure: wb_ready=0 after 2 acceptances -> S1/S2 full, req_ready=0. Raise wb_ready -> results delivered in order with no loss or duplicate.
- Flags: SUB A=0x8000_0000 B=1 -> wb_result=0x7FFF_FFFF, overflow=1. SUB A=4 B=4 -> zero=1.
- Async reset mid-flight: assert nRST between clock edges with S1 and S2 valid -> wb_valid=0 immediately, rr_ptr=0; ops are not emitted after release.
- With FU_ALU_ARB_PERF_EN: 10 accepted ops plus 3 blocked cycles -> perf_issued=10, perf_stall=3.
